// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle core's load/store/fetch requests.
// A single-ported, word-organised RAM sits behind a valid/ready request
// handshake. After a request is accepted, the block waits a fixed number of
// wait states. It then commits the access and raises a one-cycle response
// pulse that carries either read data or an error flag.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  wait-state cycles between acceptance and commit (0..15)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active-low
//   req_valid   request present
//   req_ready   responder can accept a request this cycle (IDLE only)
//   req_write   1 = store, 0 = load/fetch
//   req_addr    byte address
//   req_wdata   store data
//   rdata       load data; valid with resp_valid, held afterwards
//   resp_valid  one-cycle completion pulse
//   resp_err    qualifies resp_valid: misaligned or out-of-range access
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        resp_err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // An access fails if it is not word-aligned or falls past the last word.
  function automatic logic access_err(input logic [31:0] addr);
    access_err = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= DEPTH_W);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH];

  // Commit-side view of the request. With zero wait states the commit
  // happens on the accept edge itself, so the live inputs are used there.
  logic          commit_s;
  logic [31:0]   cmt_addr_s;
  logic          cmt_write_s;
  logic [31:0]   cmt_wdata_s;
  logic          cmt_err_s;
  logic [AW-1:0] cmt_idx_s;
  logic [31:0]   rd_word_s;
  logic          mem_we_s;
  logic          handshake_s;

  // Ready is decoded from the state register. It is forced low while reset is asserted.
  assign req_ready   = (state_q == ST_IDLE) && reset;
  assign handshake_s = req_valid && req_ready;

  assign rdata      = rdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

  // Next-state, request latching and commit decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    commit_s    = 1'b0;
    cmt_addr_s  = addr_q;
    cmt_write_s = write_q;
    cmt_wdata_s = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          cnt_d   = LAT_W;
          if (LATENCY == 0) begin
            state_d     = ST_RESP;
            commit_s    = 1'b1;
            cmt_addr_s  = req_addr;
            cmt_write_s = req_write;
            cmt_wdata_s = req_wdata;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Error check, array index and read word for the access being committed.
  always_comb begin
    cmt_err_s = access_err(cmt_addr_s);
    cmt_idx_s = cmt_addr_s[AW+1:2];
    rd_word_s = mem_q[cmt_idx_s];
  end

  // Response outputs and write enable. rdata only moves on a read or an error commit.
  always_comb begin
    resp_valid_d = commit_s;
    resp_err_d   = commit_s && cmt_err_s;
    mem_we_s     = commit_s && !cmt_err_s && cmt_write_s;
    rdata_d      = rdata_q;
    if (commit_s) begin
      if (cmt_err_s) begin
        rdata_d = 32'h0000_0000;
      end else if (!cmt_write_s) begin
        rdata_d = rd_word_s;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control, latched request and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0000_0000;
      write_q      <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage array: contents survive reset. A reset mid-transaction returns the FSM to IDLE, so no commit occurs.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[cmt_idx_s] <= cmt_wdata_s;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Two responders share one clock and one reset: dut0 has LATENCY=2 and dut1
// has LATENCY=0. Each is driven with directed and randomised transactions.
// A reference model holds the expected memory image and the last returned
// read data. That model is built from the access rules: word index = addr/4,
// error when addr%4 != 0 or addr/4 >= 64, and response one cycle after
// LATENCY wait states.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        v0, w0, rdy0, rv0, re0;
  logic [31:0] a0, d0, rd0;
  logic        v1, w1, rdy1, rv1, re1;
  logic [31:0] a1, d1, rd1;

  int n_checks;
  int n_errors;

  logic [31:0] ref_mem   [2][64];
  logic [31:0] exp_rdata [2];

  mem_responder #(.DEPTH(64), .LATENCY(2)) dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(v0), .req_ready(rdy0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0),
    .rdata(rd0), .resp_valid(rv0), .resp_err(re0)
  );

  mem_responder #(.DEPTH(64), .LATENCY(0)) dut1 (
    .clk(clk), .reset(rst_n),
    .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_wdata(d1),
    .rdata(rd1), .resp_valid(rv1), .resp_err(re1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy1 : rdy0;
  endfunction
  function automatic logic get_rv(input bit sel);
    return sel ? rv1 : rv0;
  endfunction
  function automatic logic get_re(input bit sel);
    return sel ? re1 : re0;
  endfunction
  function automatic logic [31:0] get_rd(input bit sel);
    return sel ? rd1 : rd0;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      v1 = v; w1 = w; a1 = a; d1 = d;
    end else begin
      v0 = v; w0 = w; a0 = a; d0 = d;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return (32'($urandom_range(0, 63)) * 32'd4) + 32'($urandom_range(1, 3));
      1:       return 32'h100 + 32'($urandom_range(0, 4000));
      2:       return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, 63)) * 32'd4;
    endcase
  endfunction

  // One complete transaction: accept, wait, response, then the idle cycle after it.
  task automatic txn(input bit sel, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int          lat;
    int          k;
    bit          seen;
    bit          err;
    logic [31:0] exp_rd;
    logic [5:0]  wi;
    lat = sel ? 0 : 2;
    @(negedge clk);
    check_eq("ready_idle", 32'(get_rdy(sel)), 32'd1);
    drive(sel, 1'b1, wr, addr, wd);
    err = ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'd64);
    wi  = 6'(addr / 32'd4);
    if (err) begin
      exp_rd = 32'd0;
    end else if (wr) begin
      ref_mem[sel][wi] = wd;
      exp_rd = exp_rdata[sel];
    end else begin
      exp_rd = ref_mem[sel][wi];
    end
    exp_rdata[sel] = exp_rd;
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (get_rv(sel)) begin
        seen = 1'b1;
      end else begin
        check_eq("ready_busy", 32'(get_rdy(sel)), 32'd0);
      end
    end
    if (!seen) begin
      check_eq("resp_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("resp_latency", 32'(k), 32'(lat + 1));
      check_eq("resp_err", 32'(get_re(sel)), 32'(err));
      check_eq("resp_rdata", get_rd(sel), exp_rd);
      check_eq("ready_resp", 32'(get_rdy(sel)), 32'd0);
    end
    @(negedge clk);
    check_eq("pulse_end", 32'(get_rv(sel)), 32'd0);
    check_eq("err_end", 32'(get_re(sel)), 32'd0);
    check_eq("rdata_hold", get_rd(sel), exp_rdata[sel]);
    check_eq("ready_back", 32'(get_rdy(sel)), 32'd1);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] pa;
    logic [31:0] old20;
    int          n_rdy;
    int          n_resp;
    n_checks = 0;
    n_errors = 0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("rst_ready0", 32'(rdy0), 32'd0);
    check_eq("rst_rv0", 32'(rv0), 32'd0);
    check_eq("rst_err0", 32'(re0), 32'd0);
    check_eq("rst_rdata0", rd0, 32'd0);
    check_eq("rst_ready1", 32'(rdy1), 32'd0);
    check_eq("rst_rdata1", rd1, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Known contents everywhere so any legal read has a defined answer.
    for (int i = 0; i < 64; i++) begin
      txn(1'b0, 1'b1, 32'(i) * 32'd4, $urandom | 32'h1);
      txn(1'b1, 1'b1, 32'(i) * 32'd4, $urandom | 32'h1);
    end

    // Store/load round trip, error cases and the last legal word.
    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 32'h10, 32'h0);
    check_eq("tp_deadbeef", rd0, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 32'h12, 32'h0);
    txn(1'b0, 1'b0, 32'h100, 32'h0);
    txn(1'b0, 1'b0, 32'h10, 32'h0);
    check_eq("tp_reload", rd0, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'hFC, 32'h1);
    txn(1'b0, 1'b0, 32'hFC, 32'h0);
    check_eq("tp_lastword", rd0, 32'h0000_0001);
    txn(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF);

    // req_valid held high with the address changing every cycle.
    n_rdy  = 0;
    n_resp = 0;
    @(negedge clk);
    v0 = 1'b1;
    w0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (rv0) begin
        n_resp++;
        if (q.size() > 0) begin
          pa = q.pop_front();
          exp_rdata[0] = ref_mem[0][6'(pa / 32'd4)];
        end
        check_eq("held_err", 32'(re0), 32'd0);
        check_eq("held_rdata", rd0, exp_rdata[0]);
      end
      pa = 32'($urandom_range(0, 1)) * 32'd4;
      a0 = pa;
      if (rdy0) begin
        n_rdy++;
        q.push_back(pa);
      end
    end
    v0 = 1'b0;
    check_eq("held_ready_count", 32'(n_rdy), 32'd4);
    check_eq("held_resp_count", 32'(n_resp), 32'd4);
    check_eq("held_queue_empty", 32'(q.size()), 32'd0);

    // Reset during WAIT of a store aborts it.
    txn(1'b0, 1'b0, 32'h20, 32'h0);
    old20 = ref_mem[0][8];
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(rdy0), 32'd0);
    check_eq("abort_rv", 32'(rv0), 32'd0);
    check_eq("abort_err", 32'(re0), 32'd0);
    check_eq("abort_rdata", rd0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_pulse", 32'(rv0), 32'd0);
    end
    txn(1'b0, 1'b0, 32'h20, 32'h0);
    check_eq("abort_old_data", rd0, old20);

    // Zero-latency instance.
    txn(1'b1, 1'b1, 32'h8, 32'hCAFE_F00D);
    txn(1'b1, 1'b0, 32'h8, 32'h0);
    check_eq("lat0_rdata", rd1, 32'hCAFE_F00D);
    txn(1'b1, 1'b0, 32'h3, 32'h0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      txn(1'b0, 1'($urandom), rand_addr(), $urandom);
      txn(1'b1, 1'($urandom), rand_addr(), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
